// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle CPU: control-word bit positions,
// PC source encodings and the ISA opcode map used by datapath and controller.
package mcpu_pkg;

    localparam int CW_PCWRITECOND = 16;
    localparam int CW_PCWRITE     = 15;
    localparam int CW_IORD        = 14;
    localparam int CW_MEMREAD     = 13;
    localparam int CW_MEMWRITE    = 12;
    localparam int CW_MEMTOREG    = 11;
    localparam int CW_IRWRITE     = 10;
    localparam int CW_PCSOURCE    = 8;   // [9:8]
    localparam int CW_ALUOP       = 5;   // [7:5]
    localparam int CW_ALUSRCB     = 3;   // [4:3]
    localparam int CW_ALUSRCA     = 2;
    localparam int CW_REGWRITE    = 1;
    localparam int CW_REGDST      = 0;
    localparam int CW_W           = 17;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [5:0] OP_NOOP = 6'd0;
    localparam logic [5:0] OP_MOV  = 6'd1;
    localparam logic [5:0] OP_NOT  = 6'd2;
    localparam logic [5:0] OP_ADD  = 6'd3;
    localparam logic [5:0] OP_SUB  = 6'd4;
    localparam logic [5:0] OP_OR   = 6'd5;
    localparam logic [5:0] OP_AND  = 6'd6;
    localparam logic [5:0] OP_XOR  = 6'd7;
    localparam logic [5:0] OP_SLT  = 6'd8;
    localparam logic [5:0] OP_J    = 6'd9;
    localparam logic [5:0] OP_BNE  = 6'd10;
    localparam logic [5:0] OP_ADDI = 6'd11;
    localparam logic [5:0] OP_SUBI = 6'd12;
    localparam logic [5:0] OP_ORI  = 6'd13;
    localparam logic [5:0] OP_ANDI = 6'd14;
    localparam logic [5:0] OP_XORI = 6'd15;
    localparam logic [5:0] OP_SLTI = 6'd16;
    localparam logic [5:0] OP_LI   = 6'd17;
    localparam logic [5:0] OP_LWI  = 6'd18;
    localparam logic [5:0] OP_SWI  = 6'd19;

endpackage

// File: rtl/opcode_legal_chk.sv
// Flags whether a 6-bit opcode belongs to the ISA.
module opcode_legal_chk
    import mcpu_pkg::*;
(
    input  logic [5:0] op,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_NOOP, OP_MOV, OP_NOT, OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR,
            OP_SLT, OP_J, OP_BNE, OP_ADDI, OP_SUBI, OP_ORI, OP_ANDI, OP_XORI,
            OP_SLTI, OP_LI, OP_LWI, OP_SWI: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_ir_unit.sv
// Fetch-side datapath slice: PC, IR, MDR, ALUOut, memory address mux,
// illegal-opcode sticky flag and fetched-instruction counter.
module pc_ir_unit
    import mcpu_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW_W-1:0]   ctrl_word,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [5:0]        opcode,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] imm_se,
    output logic [DATA_W-1:0] imm_ze,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] alu_out,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  instr_count
);

    logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, alu_out_q, alu_out_d;
    logic              illegal_op_q, illegal_op_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;

    logic       ir_write, pc_we, fetch_legal;
    logic [1:0] pc_source;

    // Fields consumed elsewhere in the datapath, not by this slice.
    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl_word[CW_MEMTOREG], ctrl_word[CW_ALUOP+:3],
                           ctrl_word[CW_ALUSRCB+:2], ctrl_word[CW_ALUSRCA],
                           ctrl_word[CW_REGWRITE], ctrl_word[CW_REGDST]};

    assign ir_write  = ctrl_word[CW_IRWRITE];
    assign pc_source = ctrl_word[CW_PCSOURCE+:2];
    assign pc_we     = ctrl_word[CW_PCWRITE] | (ctrl_word[CW_PCWRITECOND] & ~alu_zero);

    opcode_legal_chk u_legal (
        .op    (mem_rdata[DATA_W-1:DATA_W-6]),
        .legal (fetch_legal)
    );

    always_comb begin
        pc_d          = pc_q;
        ir_d          = ir_q;
        instr_count_d = instr_count_q;
        illegal_op_d  = illegal_op_q;
        mdr_d         = mem_rdata;
        alu_out_d     = alu_result;
        if (pc_we) begin
            case (pc_source)
                PCS_ALU:    pc_d = alu_result;
                PCS_ALUOUT: pc_d = alu_out_q;
                PCS_JUMP:   pc_d = {pc_q[DATA_W-1:26], ir_q[25:0]};
                default:    pc_d = pc_q;   // reserved encoding: hold
            endcase
        end
        if (ir_write) begin
            ir_d          = mem_rdata;
            instr_count_d = instr_count_q + CNT_W'(1);
            if (!fetch_legal) illegal_op_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= PC_RESET;
            ir_q          <= '0;
            mdr_q         <= '0;
            alu_out_q     <= '0;
            illegal_op_q  <= 1'b0;
            instr_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            mdr_q         <= mdr_d;
            alu_out_q     <= alu_out_d;
            illegal_op_q  <= illegal_op_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign mdr         = mdr_q;
    assign alu_out     = alu_out_q;
    assign illegal_op  = illegal_op_q;
    assign instr_count = instr_count_q;
    assign opcode      = ir_q[DATA_W-1:DATA_W-6];
    assign imm_se      = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign imm_ze      = {{(DATA_W-16){1'b0}}, ir_q[15:0]};
    assign mem_addr    = ctrl_word[CW_IORD] ? alu_out_q : pc_q;
    assign mem_rd      = ~reset & ctrl_word[CW_MEMREAD];
    assign mem_wr      = ~reset & ctrl_word[CW_MEMWRITE];

endmodule
